// File: rtl/fp_mult_seq.sv
// Sequential IEEE-754 binary32 multiplier: 24-step shift-add mantissa product,
// then normalise, round-to-nearest-even and pack. Same start/done handshake as the divider.
//
// state  | meaning
// GET    | latch operands
// UNPACK | split sign / biased-removed exponent / fraction
// CASES  | NaN / Inf / zero short-cuts, hidden bit insertion
// NORM_A | left-justify denormal multiplicand
// NORM_B | left-justify denormal multiplier
// MUL_0  | clear product and counter
// MUL_1  | 24 shift-add iterations
// MUL_2  | pick top 24 bits, guard/round/sticky
// NORM_1 | shift left while not normalised and above min exponent
// NORM_2 | shift right while below min exponent
// ROUND  | round to nearest even
// PACK   | assemble result and exception code
// PUT    | present result, hold until RESET
module fp_mult_seq (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] InputA,
    input  logic [31:0] InputB,
    output logic [31:0] AxB,
    output logic        DONE,
    output logic [1:0]  EXCEPTION
);

    typedef enum logic [3:0] {
        GET, UNPACK, CASES, NORM_A, NORM_B, MUL_0, MUL_1, MUL_2,
        NORM_1, NORM_2, ROUND, PACK, PUT
    } state_t;

    localparam logic signed [9:0] E_MIN  = -10'sd126;
    localparam logic signed [9:0] E_DEN  = -10'sd127;
    localparam logic signed [9:0] E_MAX  = 10'sd127;
    localparam logic signed [9:0] E_SPEC = 10'sd128;
    localparam logic [31:0]       QNAN   = 32'hFFC00000;

    state_t state, state_nxt;

    logic [31:0]        a, b, z;
    logic [23:0]        a_m, b_m, z_m;
    logic signed [9:0]  a_e, b_e, z_e;
    logic               a_s, b_s, z_s;
    logic [47:0]        prod;
    logic [4:0]         count;
    logic               guard, round_bit, sticky;
    logic [1:0]         exc_code;
    logic               out_load;

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;

    always_comb begin
        a_nan   = (a_e == E_SPEC) && (a_m != 24'd0);
        b_nan   = (b_e == E_SPEC) && (b_m != 24'd0);
        a_inf   = (a_e == E_SPEC) && (a_m == 24'd0);
        b_inf   = (b_e == E_SPEC) && (b_m == 24'd0);
        a_zero  = (a_e == E_DEN) && (a_m == 24'd0);
        b_zero  = (b_e == E_DEN) && (b_m == 24'd0);
        special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    end

    // State register: RESET overrides everything and parks the machine in GET.
    always_ff @(posedge CLOCK) begin
        if (RESET) state <= GET;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            GET:    state_nxt = UNPACK;
            UNPACK: state_nxt = CASES;
            CASES:  state_nxt = special ? PUT : NORM_A;
            NORM_A: state_nxt = a_m[23] ? NORM_B : NORM_A;
            NORM_B: state_nxt = b_m[23] ? MUL_0 : NORM_B;
            MUL_0:  state_nxt = MUL_1;
            MUL_1:  state_nxt = (count == 5'd23) ? MUL_2 : MUL_1;
            MUL_2:  state_nxt = NORM_1;
            NORM_1: state_nxt = (!z_m[23] && (z_e > E_MIN)) ? NORM_1 : NORM_2;
            NORM_2: state_nxt = (z_e < E_MIN) ? NORM_2 : ROUND;
            ROUND:  state_nxt = PACK;
            PACK:   state_nxt = PUT;
            PUT:    state_nxt = PUT;
            default: state_nxt = GET;
        endcase
    end

    always_comb begin
        out_load = (state == PUT);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            a         <= 32'd0;
            b         <= 32'd0;
            z         <= 32'd0;
            a_m       <= 24'd0;
            b_m       <= 24'd0;
            z_m       <= 24'd0;
            a_e       <= 10'sd0;
            b_e       <= 10'sd0;
            z_e       <= 10'sd0;
            a_s       <= 1'b0;
            b_s       <= 1'b0;
            z_s       <= 1'b0;
            prod      <= 48'd0;
            count     <= 5'd0;
            guard     <= 1'b0;
            round_bit <= 1'b0;
            sticky    <= 1'b0;
            exc_code  <= 2'd0;
        end else begin
            case (state)
                GET: begin
                    a <= InputA;
                    b <= InputB;
                end
                UNPACK: begin
                    a_m <= {1'b0, a[22:0]};
                    b_m <= {1'b0, b[22:0]};
                    a_e <= $signed({2'b00, a[30:23]}) - 10'sd127;
                    b_e <= $signed({2'b00, b[30:23]}) - 10'sd127;
                    a_s <= a[31];
                    b_s <= b[31];
                end
                CASES: begin
                    exc_code <= 2'd0;
                    if (a_nan || b_nan) begin
                        z        <= QNAN;
                        exc_code <= 2'd3;
                    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                        z        <= QNAN;
                        exc_code <= 2'd3;
                    end else if (a_inf || b_inf) begin
                        z <= {a_s ^ b_s, 31'h7F800000};
                    end else if (a_zero || b_zero) begin
                        z <= {a_s ^ b_s, 31'd0};
                    end else begin
                        // Denormals take the minimum exponent with no hidden bit.
                        if (a_e == E_DEN) a_e <= E_MIN;
                        else              a_m[23] <= 1'b1;
                        if (b_e == E_DEN) b_e <= E_MIN;
                        else              b_m[23] <= 1'b1;
                    end
                end
                NORM_A: begin
                    if (!a_m[23]) begin
                        a_m <= {a_m[22:0], 1'b0};
                        a_e <= a_e - 10'sd1;
                    end
                end
                NORM_B: begin
                    if (!b_m[23]) begin
                        b_m <= {b_m[22:0], 1'b0};
                        b_e <= b_e - 10'sd1;
                    end
                end
                MUL_0: begin
                    z_s   <= a_s ^ b_s;
                    prod  <= 48'd0;
                    count <= 5'd0;
                end
                MUL_1: begin
                    if (b_m[count]) prod <= prod + ({24'd0, a_m} << count);
                    count <= count + 5'd1;
                end
                MUL_2: begin
                    if (prod[47]) begin
                        z_m       <= prod[47:24];
                        guard     <= prod[23];
                        round_bit <= prod[22];
                        sticky    <= |prod[21:0];
                        z_e       <= a_e + b_e + 10'sd1;
                    end else begin
                        z_m       <= prod[46:23];
                        guard     <= prod[22];
                        round_bit <= prod[21];
                        sticky    <= |prod[20:0];
                        z_e       <= a_e + b_e;
                    end
                end
                NORM_1: begin
                    if (!z_m[23] && (z_e > E_MIN)) begin
                        z_m       <= {z_m[22:0], guard};
                        guard     <= round_bit;
                        round_bit <= 1'b0;
                        z_e       <= z_e - 10'sd1;
                    end
                end
                NORM_2: begin
                    if (z_e < E_MIN) begin
                        z_m       <= {1'b0, z_m[23:1]};
                        guard     <= z_m[0];
                        round_bit <= guard;
                        sticky    <= sticky | round_bit;
                        z_e       <= z_e + 10'sd1;
                    end
                end
                ROUND: begin
                    if (guard && (round_bit || sticky || z_m[0])) begin
                        if (z_m == 24'hFFFFFF) begin
                            z_m <= 24'h800000;
                            z_e <= z_e + 10'sd1;
                        end else begin
                            z_m <= z_m + 24'd1;
                        end
                    end
                end
                PACK: begin
                    exc_code <= 2'd0;
                    if (z_e > E_MAX) begin
                        z        <= {z_s, 31'h7F800000};
                        exc_code <= 2'd2;
                    end else if ((z_e == E_MIN) && !z_m[23]) begin
                        z        <= {z_s, 8'd0, z_m[22:0]};
                        exc_code <= 2'd1;
                    end else begin
                        z <= {z_s, z_e[7:0] + 8'd127, z_m[22:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            AxB       <= 32'd0;
            DONE      <= 1'b0;
            EXCEPTION <= 2'd0;
        end else if (out_load) begin
            AxB       <= z;
            EXCEPTION <= exc_code;
            DONE      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_mult_seq.sv
// Directed bench for fp_mult_seq: expectations queued at issue, checked by a
// monitor when DONE rises (result, exception code and completion edge).
module tb_fp_mult_seq;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] InputA = 32'd0;
    logic [31:0] InputB = 32'd0;
    logic [31:0] AxB;
    logic        DONE;
    logic [1:0]  EXCEPTION;

    fp_mult_seq dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .InputA    (InputA),
        .InputB    (InputB),
        .AxB       (AxB),
        .DONE      (DONE),
        .EXCEPTION (EXCEPTION)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [31:0] z;
        logic [1:0]  exc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;
    bit   got = 1'b0;

    // Edge 1 is the first rising edge that sees RESET low.
    always @(posedge CLOCK) edge_cnt <= RESET ? 0 : edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge CLOCK) begin
        if (DONE && !got) begin
            exp_t e;
            got = 1'b1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got AxB %h with nothing expected", AxB);
            end else begin
                e = exp_q.pop_front();
                check("axb", AxB, e.z);
                check("exception", {30'd0, EXCEPTION}, {30'd0, e.exc});
                check("done_edge", edge_cnt, e.lat);
            end
        end
    end

    task automatic reset_and_check();
        RESET = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        got = 1'b0;
        check("reset_done", {31'd0, DONE}, 32'd0);
        check("reset_axb", AxB, 32'd0);
        check("reset_exc", {30'd0, EXCEPTION}, 32'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] z, input logic [1:0] exc, input int lat);
        exp_t e;
        reset_and_check();
        InputA = a;
        InputB = b;
        e.z   = z;
        e.exc = exc;
        e.lat = lat;
        exp_q.push_back(e);
        RESET = 1'b0;
        for (int i = 0; i < 400 && !got; i++) @(negedge CLOCK);
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no DONE for %h x %h", a, b);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            repeat (3) @(negedge CLOCK);
            check("hold_done", {31'd0, DONE}, 32'd1);
            check("hold_axb", AxB, z);
        end
    endtask

    initial begin
        repeat (3) @(negedge CLOCK);

        run_op(32'h40000000, 32'h40400000, 32'h40C00000, 2'd0, 36);
        run_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 2'd0, 36);
        run_op(32'h7F800000, 32'h00000000, 32'hFFC00000, 2'd3, 4);
        run_op(32'h00000000, 32'h7F800000, 32'hFFC00000, 2'd3, 4);
        run_op(32'h7FC00001, 32'h3F800000, 32'hFFC00000, 2'd3, 4);
        run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 2'd0, 4);
        run_op(32'h80000000, 32'h3F800000, 32'h80000000, 2'd0, 4);
        run_op(32'h7F000000, 32'h7F000000, 32'h7F800000, 2'd2, 36);
        run_op(32'hFF000000, 32'h7F000000, 32'hFF800000, 2'd2, 36);
        run_op(32'h00800000, 32'h3F000000, 32'h00400000, 2'd1, 37);
        run_op(32'h00000001, 32'h00000001, 32'h00000000, 2'd1, 254);
        run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 2'd0, 36);
        run_op(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 2'd0, 36);

        // Abort a 2.0 x 3.0 run in the middle of the multiply loop.
        reset_and_check();
        InputA = 32'h40000000;
        InputB = 32'h40400000;
        RESET  = 1'b0;
        for (int i = 0; i < 100 && edge_cnt != 14; i++) @(negedge CLOCK);
        check("abort_reach_edge14", edge_cnt, 14);
        RESET = 1'b1;
        @(negedge CLOCK);
        check("abort_done", {31'd0, DONE}, 32'd0);
        check("abort_axb", AxB, 32'd0);
        check("abort_exc", {30'd0, EXCEPTION}, 32'd0);
        check("abort_no_done_seen", {31'd0, got}, 32'd0);

        run_op(32'h40800000, 32'h3E800000, 32'h3F800000, 2'd0, 36);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
